// File: rtl/redc_pkg.sv
// Shared types and constants for the REDC multiplier arbiter slice.
// The arbiter does no modular arithmetic itself. The Montgomery constants are
// kept here so that every block attached to the shared multiplier uses the
// same definitions.
package redc_pkg;

  // Coefficient width and Montgomery parameters (R = 2^12)
  localparam int W      = 12;
  localparam int Q      = 3329;
  localparam int QINV   = 3327;   // -q^-1 mod R
  localparam int R2_MOD = 2385;   // R^2 mod q, used to enter the Montgomery domain

  // Width of a requester index carried through the tag pipeline
  localparam int IDX_W  = 8;

  typedef logic [W-1:0]     coef_t;
  typedef logic [IDX_W-1:0] idx_t;

  // One in-flight multiplier op: whether it is live, and who owns the result
  typedef struct packed {
    logic vld;
    idx_t idx;
  } redc_tag_t;

  // Round-robin successor of index g among n requesters
  function automatic idx_t rr_next(input idx_t g, input int n);
    if (int'(g) >= n - 1) begin
      return '0;
    end
    return g + idx_t'(1);
  endfunction

endpackage

// File: rtl/redc_resp_fifo.sv
// Per-requester response FIFO. The storage is registered and the head is read
// straight out of the array. Overflow protection is the job of the upstream
// credit scheme, so push is never gated here.
module redc_resp_fifo
  import redc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push_i,
  input  logic  pop_i,
  input  coef_t data_i,
  output coef_t data_o,
  output logic  empty_o,
  output logic  full_o
);

  // A DEPTH of 1 still needs a 1-bit pointer; the spare slot is never live
  // because the occupancy count caps the FIFO at DEPTH entries.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  coef_t mem_q [1 << AW];
  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  count_q, count_d;
  logic  do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == cnt_t'(DEPTH));
  assign data_o  = mem_q[rd_ptr_q];

  // A pop is only meaningful when the head is valid
  assign do_pop = pop_i && !empty_o;

  // Next-state pointers and occupancy; push and pop together leave the count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Result storage; data only, so it is not reset
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/redc_mul_arbiter.sv
// Round-robin front end for one shared pipelined REDC multiplier.
// One operand pair is issued per cycle at most. The owner of each in-flight op
// rides a tag pipeline matched to the multiplier latency. Results land in a
// per-requester FIFO, and credits keep every FIFO from overflowing.
module redc_mul_arbiter
  import redc_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic  [N_REQ-1:0]  req_valid,
  output logic  [N_REQ-1:0]  req_ready,
  input  coef_t [N_REQ-1:0]  req_a,
  input  coef_t [N_REQ-1:0]  req_b,
  output logic  [N_REQ-1:0]  resp_valid,
  input  logic  [N_REQ-1:0]  resp_ready,
  output coef_t [N_REQ-1:0]  resp_r,
  output logic               mul_valid,
  output coef_t              mul_a,
  output coef_t              mul_b,
  input  coef_t              mul_r,
  output logic               busy
);

  localparam int CW = $clog2(DEPTH + 1);
  typedef logic [CW-1:0] credit_t;

  // Credit per requester = FIFO slots not yet promised to an issued op
  credit_t    credit_q [N_REQ];
  credit_t    credit_d [N_REQ];
  idx_t       rr_q, rr_d;
  redc_tag_t  tag_q [LAT];

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] pop;
  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] fifo_empty;
  logic [N_REQ-1:0] fifo_full;
  logic [LAT-1:0]   tag_vld;
  idx_t             gnt_idx;
  logic             gnt_any;

  // A requester may compete only while it still holds a free result slot
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] && (credit_q[i] != '0);
    end
  end

  // Round-robin pick: first eligible index at or above rr_q, else first from 0
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any && eligible[i] && (idx_t'(i) >= rr_q)) begin
        grant[i] = 1'b1;
        gnt_idx  = idx_t'(i);
        gnt_any  = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any && eligible[i]) begin
        grant[i] = 1'b1;
        gnt_idx  = idx_t'(i);
        gnt_any  = 1'b1;
      end
    end
  end

  // Issue mux: granted operands go to the multiplier, zeros when idle
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        mul_a = req_a[i];
        mul_b = req_b[i];
      end
    end
  end

  assign req_ready = grant;
  assign mul_valid = gnt_any;
  assign pop       = resp_valid & resp_ready;
  assign rr_d      = gnt_any ? rr_next(gnt_idx, N_REQ) : rr_q;

  // Credit bookkeeping: a grant takes a slot and a pop returns one
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      case ({grant[i], pop[i]})
        2'b10:   credit_d[i] = credit_q[i] - credit_t'(1);
        2'b01:   credit_d[i] = credit_q[i] + credit_t'(1);
        default: credit_d[i] = credit_q[i];
      endcase
    end
  end

  // Round-robin pointer and credit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        credit_q[i] <= credit_t'(DEPTH);
      end
    end else begin
      rr_q <= rr_d;
      for (int i = 0; i < N_REQ; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

  // Tag pipeline tracking the owner of each op through the multiplier.
  // Clearing it on reset is what makes stale multiplier results harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= {gnt_any, gnt_idx};
      for (int s = 1; s < LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // Steer the emerging result to its owner's FIFO
  always_comb begin
    push = '0;
    for (int i = 0; i < N_REQ; i++) begin
      push[i] = tag_q[LAT-1].vld && (tag_q[LAT-1].idx == idx_t'(i));
    end
  end

  // Collect live flags so busy covers every op still inside the multiplier
  always_comb begin
    tag_vld = '0;
    for (int s = 0; s < LAT; s++) begin
      tag_vld[s] = tag_q[s].vld;
    end
  end

  assign busy = (|tag_vld) || (|resp_valid);

  for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
    redc_resp_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .data_i  (mul_r),
      .data_o  (resp_r[g]),
      .empty_o (fifo_empty[g]),
      .full_o  (fifo_full[g])
    );
    assign resp_valid[g] = !fifo_empty[g];
  end

  // Credits must make a push into a full FIFO impossible
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    (push & fifo_full) == '0);

endmodule

// File: tb/tb_redc_mul_arbiter.sv
// Bench for redc_mul_arbiter: a LAT-stage behavioural REDC multiplier plus a
// reference model that keeps, per requester, the ordered list of results
// still owed (in flight or queued) together with the cycle each becomes visible.
module tb_redc_mul_arbiter;

  localparam int N     = 2;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int Q     = 3329;
  localparam int RINV  = 2704;   // 2^-12 mod 3329

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid, req_ready, resp_valid, resp_ready;
  logic [N-1:0][11:0]   req_a, req_b, resp_r;
  logic                 mul_valid, busy;
  logic [11:0]          mul_a, mul_b, mul_r;
  logic [11:0]          pr [LAT];

  int checks = 0;
  int errors = 0;

  typedef struct { int val; int rdy; } exp_t;
  exp_t expq [N][$];
  int   rr_m;
  int   cyc;

  logic [N-1:0]       s_ready, s_rvalid;
  logic [N-1:0][11:0] s_r;
  logic               s_mv, s_busy;

  always #5 clk = ~clk;

  redc_mul_arbiter #(.N_REQ(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_r     (resp_r),
    .mul_valid  (mul_valid),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_r      (mul_r),
    .busy       (busy)
  );

  function automatic int redc_ref(input int a, input int b);
    return (((a * b) % Q) * RINV) % Q;
  endfunction

  // Attached multiplier: result appears LAT cycles after issue, noise otherwise
  always @(posedge clk) begin
    pr[0] <= mul_valid ? 12'(redc_ref(int'(mul_a), int'(mul_b)))
                       : 12'($urandom_range(0, 4095));
    for (int s = 1; s < LAT; s++) pr[s] <= pr[s-1];
  end
  assign mul_r = pr[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: check every output against the model mid-cycle, then advance it
  task automatic tick();
    int g, ea, eb;
    logic [N-1:0] exp_rdy;
    logic exp_busy, ev;
    @(negedge clk);
    s_ready = req_ready; s_rvalid = resp_valid; s_r = resp_r;
    s_mv = mul_valid; s_busy = busy;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr_m + k) % N;
      if (g < 0 && req_valid[j] && expq[j].size() < DEPTH) g = j;
    end
    exp_rdy = '0; ea = 0; eb = 0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      ea = int'(req_a[g]);
      eb = int'(req_b[g]);
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("mul_valid", 32'(mul_valid), 32'(g >= 0));
    chk("mul_a", 32'(mul_a), ea);
    chk("mul_b", 32'(mul_b), eb);
    exp_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (expq[i].size() > 0) exp_busy = 1'b1;
      ev = (expq[i].size() > 0) && (expq[i][0].rdy <= cyc);
      chk($sformatf("resp_valid%0d", i), 32'(resp_valid[i]), 32'(ev));
      if (ev) begin
        chk($sformatf("resp_r%0d", i), 32'(resp_r[i]), expq[i][0].val);
        if (resp_ready[i]) void'(expq[i].pop_front());
      end
    end
    chk("busy", 32'(busy), 32'(exp_busy));
    if (g >= 0) begin
      expq[g].push_back('{val: redc_ref(ea, eb), rdy: cyc + LAT + 1});
      rr_m = (g + 1) % N;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i] = 12'($urandom_range(0, Q - 1));
      req_b[i] = 12'($urandom_range(0, Q - 1));
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gcyc, lat, n0, n1, cnt;
    logic [N-1:0] prev, nxt;
    logic seen;

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = '0;
    cyc = 0; rr_m = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_mul_valid", 32'(mul_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;

    // Single op: R^2 * 1 comes back as R mod q
    resp_ready = '1;
    req_valid = 2'b01; req_a[0] = 12'd2385; req_b[0] = 12'd1;
    tick();
    chk("single_grant", 32'(s_ready), 1);
    gcyc = cyc - 1;
    req_valid = '0;
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      tick();
      if (s_rvalid[0]) begin
        lat = (cyc - 1) - gcyc;
        chk("single_r", 32'(s_r[0]), 767);
      end
    end
    chk("single_latency", lat, LAT + 1);
    repeat (2) tick();
    chk("single_busy_drop", 32'(s_busy), 0);

    // Identity and zero, delivered in issue order
    resp_ready = '0;
    req_valid = 2'b01; req_a[0] = 12'd767; req_b[0] = 12'd767;
    tick();
    req_a[0] = 12'd0; req_b[0] = 12'd3328;
    tick();
    req_valid = '0;
    repeat (LAT + 1) tick();
    resp_ready = 2'b01;
    tick();
    chk("ident_first", 32'(s_r[0]), 767);
    tick();
    chk("zero_second", 32'(s_r[0]), 0);
    resp_ready = '1;

    // Idle: nothing issued, pointer left where the last grant put it
    repeat (3) begin
      tick();
      chk("idle_mul_valid", 32'(s_mv), 0);
    end

    // Fairness: both requesting, responses always accepted
    req_valid = '1; rand_ops();
    tick();
    chk("idle_rr_kept", 32'(s_ready), 32'(2'b10));
    prev = s_ready;
    for (int k = 0; k < 10; k++) begin
      rand_ops();
      tick();
      nxt = ~prev;
      chk("fair_alt", 32'(s_ready), 32'(nxt));
      chk("fair_mul_valid", 32'(s_mv), 1);
      prev = s_ready;
    end

    // Drain, then backpressure requester 0
    req_valid = '0;
    repeat (8) tick();
    resp_ready = 2'b10; req_valid = '1;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 16; k++) begin
      rand_ops();
      tick();
      n0 += int'(s_ready[0]);
      if (k >= 8) n1 += int'(s_ready[1]);
    end
    chk("bp_req0_grants", n0, DEPTH);
    chk("bp_req1_share", 32'(n1 >= 6), 1);
    resp_ready = 2'b11;
    rand_ops();
    tick();
    n0 = int'(s_ready[0]);
    resp_ready = 2'b10;
    for (int k = 0; k < 6; k++) begin
      rand_ops();
      tick();
      n0 += int'(s_ready[0]);
    end
    chk("bp_one_more", n0, 1);

    // Same-cycle grant and pop on requester 0 while its credit is 1
    req_valid = '0; resp_ready = '1;
    repeat (10) tick();
    req_valid = 2'b01; resp_ready = '0;
    cnt = 0;
    for (int k = 0; k < 10 && cnt < DEPTH - 1; k++) begin
      rand_ops();
      tick();
      cnt += int'(s_ready[0]);
    end
    chk("gp_setup", cnt, DEPTH - 1);
    req_valid = '0;
    repeat (LAT + 2) tick();
    req_valid = 2'b01; resp_ready = 2'b01; rand_ops();
    tick();
    chk("gp_grant", 32'(s_ready[0]), 1);
    chk("gp_pop", 32'(s_rvalid[0]), 1);
    resp_ready = '0;
    n0 = 0;
    for (int k = 0; k < 8; k++) begin
      rand_ops();
      tick();
      n0 += int'(s_ready[0]);
    end
    chk("gp_credit_kept", n0, 1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) resp_ready[i] = ($urandom_range(0, 3) != 0);
      rand_ops();
      tick();
    end

    // Reset with three ops in flight
    req_valid = '0; resp_ready = '1;
    repeat (10) tick();
    req_valid = '1;
    repeat (3) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_resp_valid", 32'(resp_valid), 0);
    chk("rstmid_busy", 32'(busy), 0);
    for (int i = 0; i < N; i++) expq[i].delete();
    rr_m = 0;
    @(posedge clk); #1;
    cyc++;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (s_rvalid != '0) seen = 1'b1;
    end
    chk("rstmid_no_resp", 32'(seen), 0);

    // Pointer restarts at 0 after reset
    req_valid = '1; rand_ops();
    tick();
    chk("rst_rr_zero", 32'(s_ready), 32'(2'b01));
    repeat (4) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
